vga_mem_reader: RTL and testbench

VGA_MEM_READER -- requirements
Module: vga_mem_reader

---
 rtl/vga_mem_reader.sv | 138 +++++++++++++
 tb/tb_vga_mem_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_reader.sv
// vga_mem_reader: fetches the display operand block from data memory once per frame.
// Optional VGA_READER_VALID_WORD_EN adds a sixth word whose bit0 gates the commit.
module vga_mem_reader #(
  parameter logic [15:0] BASE_ADR = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        clr_overrun,
  output logic        mem_rd,
  output logic [15:0] mem_adr,
  input  logic [15:0] mem_data,
  output logic [15:0] value,
  output logic [15:0] p1,
  output logic [15:0] p2,
  output logic [15:0] p3,
  output logic [15:0] p4,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

`ifdef VGA_READER_VALID_WORD_EN
  localparam int N = 6;
`else
  localparam int N = 5;
`endif
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_COMMIT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_k;
  logic [15:0] r_sh [N];
  logic [15:0] r_out [5];
  logic        r_rd;
  logic [15:0] r_adr;
  logic        r_done;
  logic        r_ovr;

  logic [2:0]  w_next_k;
  logic        w_miss;
  logic        w_load;

  assign w_next_k = r_k + 3'd1;
  assign w_miss   = frame_start &&
                    (r_state == S_FETCH || r_state == S_DRAIN);
`ifdef VGA_READER_VALID_WORD_EN
  assign w_load   = r_sh[5][0];
`else
  assign w_load   = 1'b1;
`endif

  // Frame fetch sequencer: strobe N words, drain last read, commit atomically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_rd    <= 1'b0;
      r_adr   <= BASE_ADR;
      r_done  <= 1'b0;
      for (int i = 0; i < N; i++) r_sh[i] <= 16'h0000;
      for (int i = 0; i < 5; i++) r_out[i] <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_FETCH;
            r_k     <= 3'd0;
            r_rd    <= 1'b1;
            r_adr   <= BASE_ADR;
          end
        end
        S_FETCH: begin
          if (r_k != 3'd0) r_sh[r_k - 3'd1] <= mem_data;
          if (r_k == LAST) begin
            r_state <= S_DRAIN;
            r_rd    <= 1'b0;
            r_adr   <= BASE_ADR;
          end else begin
            r_k   <= w_next_k;
            r_adr <= BASE_ADR + {13'd0, w_next_k};
          end
        end
        S_DRAIN: begin
          r_sh[LAST] <= mem_data;
          r_k        <= 3'd0;
          r_done     <= 1'b1;
          r_state    <= S_COMMIT;
        end
        S_COMMIT: begin
          if (w_load) begin
            for (int i = 0; i < 5; i++) r_out[i] <= r_sh[i];
          end
          // A start arriving as we return to idle begins the next frame.
          if (frame_start) begin
            r_state <= S_FETCH;
            r_k     <= 3'd0;
            r_rd    <= 1'b1;
            r_adr   <= BASE_ADR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky overrun: a missed start outranks a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr <= 1'b0;
    end else if (w_miss) begin
      r_ovr <= 1'b1;
    end else if (clr_overrun) begin
      r_ovr <= 1'b0;
    end
  end

  assign mem_rd     = r_rd;
  assign mem_adr    = r_adr;
  assign value      = r_out[0];
  assign p1         = r_out[1];
  assign p2         = r_out[2];
  assign p3         = r_out[3];
  assign p4         = r_out[4];
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_vga_mem_reader.sv
// tb_vga_mem_reader: directed/randomized bench for vga_mem_reader.
// Reference: per-frame timeline computed from E0 plus memory snapshots.
module tb_vga_mem_reader;

`ifdef VGA_READER_VALID_WORD_EN
  localparam int N = 6;
`else
  localparam int N = 5;
`endif
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] BASE2 = 16'hFFFE;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        clr;
  logic        mem_rd;
  logic [15:0] mem_adr;
  logic [15:0] mem_data;
  logic [15:0] value, p1, p2, p3, p4;
  logic        busy, frame_done, overrun;

  logic        fs2;
  logic        clr2;
  logic        mem_rd2;
  logic [15:0] mem_adr2;
  logic [15:0] mem_data2;
  logic [15:0] v2, q1, q2, q3, q4;
  logic        busy2, done2, ovr2;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_out [5];
  logic [15:0] exp2 [5];
  logic        exp_ovr;
  int          n_chk;
  int          n_fail;
  int          nfr;

  vga_mem_reader #(.BASE_ADR(BASE)) dut (
    .clk(clk), .rst(rst), .frame_start(fs), .clr_overrun(clr),
    .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_data(mem_data),
    .value(value), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  vga_mem_reader #(.BASE_ADR(BASE2)) dut2 (
    .clk(clk), .rst(rst), .frame_start(fs2), .clr_overrun(clr2),
    .mem_rd(mem_rd2), .mem_adr(mem_adr2), .mem_data(mem_data2),
    .value(v2), .p1(q1), .p2(q2), .p3(q3), .p4(q4),
    .busy(busy2), .frame_done(done2), .overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_adr];
    if (mem_rd2) mem_data2 <= mem[mem_adr2];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".value"}, value, exp_out[0]);
    chk({tag, ".p1"}, p1, exp_out[1]);
    chk({tag, ".p2"}, p2, exp_out[2]);
    chk({tag, ".p3"}, p3, exp_out[3]);
    chk({tag, ".p4"}, p4, exp_out[4]);
  endtask

  // One frame on dut; E0 is the edge sampling the start pulse.
  task automatic frame(input bit started, input int extra_at,
                       input int clr_at, input bit chain);
    logic [15:0] snap [6];
    logic [15:0] a;
    bit          upd;
    if (!started) begin
      fs = 1'b1;
      step();
    end
    fs = 1'b0;
    nfr++;
    for (int i = 0; i < 6; i++) begin
      a = BASE + 16'(i);
      mem[a] = 16'($urandom);
    end
`ifdef VGA_READER_VALID_WORD_EN
    a = BASE + 16'd5;
    mem[a][0] = nfr[0];
`endif
    for (int i = 0; i < 6; i++) begin
      a = BASE + 16'(i);
      snap[i] = mem[a];
    end
    upd = (N == 5) ? 1'b1 : snap[5][0];
    for (int c = 0; c <= N + 2; c++) begin
      if (c > 0) step();
      chk("busy", {15'd0, busy}, {15'd0, (c <= N + 1) || chain});
      chk("mem_rd", {15'd0, mem_rd},
          {15'd0, (c < N) || (c == N + 2 && chain)});
      chk("mem_adr", mem_adr, (c < N) ? BASE + 16'(c) : BASE);
      chk("frame_done", {15'd0, frame_done}, {15'd0, c == N + 1});
      if (c == N + 1) chk_outs("old");
      if (c == N + 2) begin
        if (upd) for (int i = 0; i < 5; i++) exp_out[i] = snap[i];
        chk_outs("new");
      end
      if (c == extra_at) fs = 1'b1;
      if (c == extra_at + 1) fs = 1'b0;
      if (c == clr_at) clr = 1'b1;
      if (c == clr_at + 1) clr = 1'b0;
      if (chain && c == N + 1) fs = 1'b1;
    end
    if (extra_at >= 0) exp_ovr = !(clr_at > extra_at);
    else if (clr_at >= 0) exp_ovr = 1'b0;
    chk("overrun", {15'd0, overrun}, {15'd0, exp_ovr});
  endtask

  initial begin
    int m;
    logic [15:0] a;
    bit upd2;
    n_chk = 0;
    n_fail = 0;
    nfr = 0;
    rst = 1'b0;
    fs = 1'b0;
    clr = 1'b0;
    fs2 = 1'b0;
    clr2 = 1'b0;
    exp_ovr = 1'b0;
    for (int i = 0; i < 5; i++) exp_out[i] = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    #12;
    chk_outs("rst");
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst.mem_adr", mem_adr, BASE);
    chk("rst.done", {15'd0, frame_done}, 16'd0);
    chk("rst.ovr", {15'd0, overrun}, 16'd0);
    chk("rst.adr2", mem_adr2, BASE2);
    rst = 1'b1;
    step();

    frame(0, -1, -1, 0);
    frame(0, 2, -1, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_ovr = 1'b0;
    chk("clr.ovr", {15'd0, overrun}, 16'd0);
    m = $urandom_range(0, N);
    frame(0, m, m, 0);

    fs = 1'b1;
    step();
    fs = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) exp_out[i] = 16'h0000;
    exp_ovr = 1'b0;
    chk_outs("midrst");
    chk("midrst.busy", {15'd0, busy}, 16'd0);
    chk("midrst.mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("midrst.mem_adr", mem_adr, BASE);
    chk("midrst.ovr", {15'd0, overrun}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst.done", {15'd0, frame_done}, 16'd0);
    end
    rst = 1'b1;
    step();
    chk("postrst.busy", {15'd0, busy}, 16'd0);
    chk_outs("postrst");

    frame(0, -1, -1, 1);
    frame(1, -1, -1, 1);
    frame(1, -1, -1, 0);
    repeat (4) frame(0, -1, -1, 0);

    upd2 = 1'b1;
`ifdef VGA_READER_VALID_WORD_EN
    a = BASE2 + 16'd5;
    mem[a][0] = 1'b1;
`endif
    for (int i = 0; i < 5; i++) begin
      a = BASE2 + 16'(i);
      exp2[i] = mem[a];
    end
    fs2 = 1'b1;
    step();
    fs2 = 1'b0;
    for (int c = 0; c <= N + 2; c++) begin
      if (c > 0) step();
      chk("wrap.mem_rd", {15'd0, mem_rd2}, {15'd0, c < N});
      if (c < N) chk("wrap.mem_adr", mem_adr2, BASE2 + 16'(c));
    end
    if (upd2) begin
      chk("wrap.value", v2, exp2[0]);
      chk("wrap.p1", q1, exp2[1]);
      chk("wrap.p2", q2, exp2[2]);
      chk("wrap.p3", q3, exp2[3]);
      chk("wrap.p4", q4, exp2[4]);
    end
    chk("wrap.busy", {15'd0, busy2}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
